fetch_stage: RTL



---
 rtl/cpu_pkg.sv | 23 ++
 rtl/next_pc_gen.sv | 28 ++
 rtl/fetch_stage.sv | 104 ++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// Shared types and constants for the instruction fetch stage.
package cpu_pkg;

    // Fetch sequencer states.
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_REQ   = 2'd1,
        S_HOLD  = 2'd2,
        S_FAULT = 2'd3
    } fetch_state_t;

    // ADDI x0, x0, 0: the canonical RISC-V no-op.
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    // Sequential fetch increment in bytes.
    localparam int unsigned PC_STEP = 4;

    // A fetch target must be word aligned.
    function automatic logic word_misaligned(input logic [1:0] low_bits);
        return (low_bits != 2'b00);
    endfunction

endpackage

// File: rtl/next_pc_gen.sv
// Next-PC selection for the fetch stage: JALR target, branch/JAL target
// or the sequential successor, plus a misalignment flag for the result.
module next_pc_gen
    import cpu_pkg::*;
#(
    parameter int unsigned ADDR_W = 32
) (
    input  logic [ADDR_W-1:0] instr_pc,
    input  logic              PCsrc,
    input  logic              reg_jump,
    input  logic [31:0]       imm_ext,
    input  logic [ADDR_W-1:0] jalr_target,
    output logic [ADDR_W-1:0] next_pc,
    output logic              misaligned
);

    // reg_jump has priority over PCsrc; JALR clears bit 0 of its target.
    always_comb begin
        next_pc = instr_pc + ADDR_W'(PC_STEP);
        if (reg_jump) begin
            next_pc = jalr_target & ~ADDR_W'(1);
        end else if (PCsrc) begin
            next_pc = instr_pc + imm_ext[ADDR_W-1:0];
        end
        misaligned = word_misaligned(next_pc[1:0]);
    end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: owns the PC, fetches from a variable-latency
// instruction memory over req/ack, presents each word over valid/ready and
// advances the PC from the decode unit's control outputs on retirement.
module fetch_stage
    import cpu_pkg::*;
#(
    parameter int unsigned ADDR_W   = 32,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic              clk,
    input  logic              rst,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_ack,
    input  logic [31:0]       imem_rdata,
    output logic              instr_valid,
    input  logic              instr_ready,
    output logic [31:0]       instr,
    output logic [ADDR_W-1:0] instr_pc,
    output logic [ADDR_W-1:0] pc_plus4,
    input  logic              PCsrc,
    input  logic              reg_jump,
    input  logic [31:0]       imm_ext,
    input  logic [ADDR_W-1:0] jalr_target,
    output logic              fetch_fault
);

    localparam logic [ADDR_W-1:0] RESET_PC_W = RESET_PC[ADDR_W-1:0];

    fetch_state_t      state;
    logic [ADDR_W-1:0] pc;
    logic [ADDR_W-1:0] next_pc;
    logic              next_misaligned;

    // The address bus is the PC register itself; it only matters while imem_req=1.
    assign imem_addr = pc;

    next_pc_gen #(
        .ADDR_W (ADDR_W)
    ) u_next_pc_gen (
        .instr_pc    (instr_pc),
        .PCsrc       (PCsrc),
        .reg_jump    (reg_jump),
        .imm_ext     (imm_ext),
        .jalr_target (jalr_target),
        .next_pc     (next_pc),
        .misaligned  (next_misaligned)
    );

    // Fetch sequencer with all handshake outputs registered alongside the state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_IDLE;
            pc          <= RESET_PC_W;
            instr       <= NOP_INSTR;
            instr_pc    <= RESET_PC_W;
            pc_plus4    <= RESET_PC_W + ADDR_W'(PC_STEP);
            instr_valid <= 1'b0;
            imem_req    <= 1'b0;
            fetch_fault <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    state    <= S_REQ;
                    imem_req <= 1'b1;
                end
                S_REQ: begin
                    if (imem_ack) begin
                        instr       <= imem_rdata;
                        instr_pc    <= pc;
                        pc_plus4    <= pc + ADDR_W'(PC_STEP);
                        instr_valid <= 1'b1;
                        imem_req    <= 1'b0;
                        state       <= S_HOLD;
                    end
                end
                S_HOLD: begin
                    if (instr_ready) begin
                        instr_valid <= 1'b0;
                        if (next_misaligned) begin
                            fetch_fault <= 1'b1;
                            state       <= S_FAULT;
                        end else begin
                            pc       <= next_pc;
                            imem_req <= 1'b1;
                            state    <= S_REQ;
                        end
                    end
                end
                S_FAULT: begin
                    instr_valid <= 1'b0;
                    imem_req    <= 1'b0;
                    fetch_fault <= 1'b1;
                end
                default: begin
                    state       <= S_IDLE;
                    instr_valid <= 1'b0;
                    imem_req    <= 1'b0;
                end
            endcase
        end
    end

endmodule
